// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared encodings for the bus-cycle sequencer and the data bus buffer.
package bus_cycle_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      TW   = 3'd3,
      T3   = 3'd4
   } bus_state_e;

   // Buffer direction encoding, shared with the in/out buffer
   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/bus_cycle_ctrl_wait_state_ctr.sv
// Wait-state down-counter (MIN_WAIT) and saturating READY-low up-counter (TIMEOUT).
module wait_state_ctr #(
   parameter int MIN_WAIT = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  logic enable,
   input  logic ready,
   output logic wait_zero,
   output logic expired
);

   logic [3:0] wait_cnt;
   logic [7:0] tmo_cnt;
   logic       tmo_inc;

   // The cycle that decrements 1->0 already samples READY, so MIN_WAIT=N gives N wait cycles
   assign wait_zero = (wait_cnt <= 4'd1);
   assign tmo_inc   = enable && wait_zero && !ready;
   assign expired   = tmo_inc && (tmo_cnt >= 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         if (load)
            wait_cnt <= 4'(MIN_WAIT);
         else if (enable && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;

         if (clr)
            tmo_cnt <= '0;
         else if (tmo_inc && tmo_cnt != 8'hFF)
            tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// External bus-cycle sequencer: T1 address, T2 strobe, TW wait states, T3 termination.
module bus_cycle_ctrl
   import bus_cycle_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int MIN_WAIT = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic              READY,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [ADDR_W-1:0] AddrBus,
   output logic              ALE,
   output logic              RD_n,
   output logic              WR_n,
   output logic              Internal_RD_WR,
   output logic              RD_WR
);

   bus_state_e state, state_nxt;
   logic       cyc_we;
   logic       accept, done_set, tmo_set;
   logic       wait_zero, expired, strobe;

   wait_state_ctr #(
      .MIN_WAIT (MIN_WAIT),
      .TIMEOUT  (TIMEOUT)
   ) u_wait_ctr (
      .clk       (clk),
      .rst       (rst),
      .clr       (accept),
      .load      (state == T2),
      .enable    (state == TW),
      .ready     (READY),
      .wait_zero (wait_zero),
      .expired   (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cyc_we  <= DIR_RD;
         AddrBus <= '0;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         done    <= done_set;
         timeout <= tmo_set;
         if (accept) begin
            cyc_we  <= we;
            AddrBus <= addr;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done_set  = 1'b0;
      tmo_set   = 1'b0;
      case (state)
         IDLE: if (req) begin
            accept    = 1'b1;
            state_nxt = T1;
         end
         T1: state_nxt = T2;
         T2: state_nxt = (MIN_WAIT == 0 && READY) ? T3 : TW;
         TW: begin
            if (wait_zero && READY) begin
               state_nxt = T3;
            end else if (expired) begin
               state_nxt = IDLE;
               tmo_set   = 1'b1;
            end
         end
         T3: begin
            state_nxt = IDLE;
            done_set  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cyc_we only changes on acceptance, so direction is stable under any strobe
   assign busy           = (state != IDLE);
   assign ALE            = (state == T1);
   assign strobe         = (state inside {T2, TW, T3});
   assign RD_n           = !(strobe && cyc_we == DIR_RD);
   assign WR_n           = !(strobe && cyc_we == DIR_WR);
   assign Internal_RD_WR = busy ? cyc_we : DIR_RD;
   assign RD_WR          = busy ? cyc_we : DIR_RD;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench: dut 0 (MIN_WAIT=0,TIMEOUT=255), dut 1 (MIN_WAIT=2), dut 2 (TIMEOUT=4).
module tb_bus_cycle_ctrl;

   // {busy, done, timeout, ALE, RD_n, WR_n, Internal_RD_WR, RD_WR}
   localparam logic [7:0] O_IDLE = 8'b0000_1100;
   localparam logic [7:0] O_T1_R = 8'b1001_1100;
   localparam logic [7:0] O_T1_W = 8'b1001_1111;
   localparam logic [7:0] O_ST_R = 8'b1000_0100;
   localparam logic [7:0] O_ST_W = 8'b1000_1011;
   localparam logic [7:0] O_DONE = 8'b0100_1100;
   localparam logic [7:0] O_TMO  = 8'b0010_1100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req   [3];
   logic        we    [3];
   logic [15:0] addr  [3];
   logic        ready [3];
   logic        busy  [3];
   logic        done  [3];
   logic        tmo   [3];
   logic [15:0] abus  [3];
   logic        ale   [3];
   logic        rd_n  [3];
   logic        wr_n  [3];
   logic        ird   [3];
   logic        rdwr  [3];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bus_cycle_ctrl #(
         .ADDR_W   (16),
         .MIN_WAIT (g == 1 ? 2 : 0),
         .TIMEOUT  (g == 2 ? 4 : 255)
      ) dut (
         .clk            (clk),
         .rst            (rst),
         .req            (req[g]),
         .we             (we[g]),
         .addr           (addr[g]),
         .READY          (ready[g]),
         .busy           (busy[g]),
         .done           (done[g]),
         .timeout        (tmo[g]),
         .AddrBus        (abus[g]),
         .ALE            (ale[g]),
         .RD_n           (rd_n[g]),
         .WR_n           (wr_n[g]),
         .Internal_RD_WR (ird[g]),
         .RD_WR          (rdwr[g])
      );
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic co(input int i, input string tag, input logic [7:0] exp);
      logic [7:0] o;
      o = {busy[i], done[i], tmo[i], ale[i], rd_n[i], wr_n[i], ird[i], rdwr[i]};
      chk(tag, {8'h00, o}, {8'h00, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; ready[i] = 1'b0;
      end
      step(); step();
      for (int i = 0; i < 3; i++) begin
         co(i, "reset_outs", O_IDLE);
         chk("reset_addr", abus[i], 16'h0000);
      end
      rst = 1'b0;
      step();

      // read, no wait states; mid-cycle addr/we changes must be ignored
      req[0] = 1; we[0] = 0; addr[0] = 16'h1234; ready[0] = 1;
      step(); co(0, "rd_t1", O_T1_R); chk("rd_t1_addr", abus[0], 16'h1234);
      req[0] = 0; addr[0] = 16'hFFFF; we[0] = 1;
      step(); co(0, "rd_t2", O_ST_R);
      step(); co(0, "rd_t3", O_ST_R); chk("rd_t3_addr", abus[0], 16'h1234);
      step(); co(0, "rd_done", O_DONE);
      step(); co(0, "rd_idle", O_IDLE);

      // write, READY low through T2, TW1, TW2
      req[0] = 1; we[0] = 1; addr[0] = 16'hABCD; ready[0] = 0;
      step(); co(0, "wr_t1", O_T1_W); chk("wr_t1_addr", abus[0], 16'hABCD);
      req[0] = 0;
      step(); co(0, "wr_t2", O_ST_W);
      step(); co(0, "wr_tw1", O_ST_W);
      step(); co(0, "wr_tw2", O_ST_W);
      step(); co(0, "wr_tw3", O_ST_W);
      ready[0] = 1;
      step(); co(0, "wr_t3", O_ST_W);
      step(); co(0, "wr_done", O_DONE);
      step(); co(0, "wr_idle", O_IDLE);

      // MIN_WAIT=2, READY high: T2, TW, TW, T3 then done
      req[1] = 1; we[1] = 0; addr[1] = 16'h5555; ready[1] = 1;
      step(); co(1, "mw_t1", O_T1_R);
      req[1] = 0;
      step(); co(1, "mw_t2", O_ST_R);
      step(); co(1, "mw_tw1", O_ST_R);
      step(); co(1, "mw_tw2", O_ST_R);
      step(); co(1, "mw_t3", O_ST_R);
      step(); co(1, "mw_done", O_DONE);
      step(); co(1, "mw_idle", O_IDLE);

      // TIMEOUT=4, READY low: four TW cycles, then timeout pulse
      req[2] = 1; we[2] = 1; addr[2] = 16'h0F0F; ready[2] = 0;
      step(); co(2, "to_t1", O_T1_W);
      req[2] = 0;
      step(); co(2, "to_t2", O_ST_W);
      for (int k = 0; k < 4; k++) begin
         step(); co(2, "to_tw", O_ST_W);
      end
      step(); co(2, "to_pulse", O_TMO);
      step(); co(2, "to_idle", O_IDLE);
      req[2] = 1; we[2] = 0; addr[2] = 16'h0001; ready[2] = 1;
      step(); co(2, "to_next_t1", O_T1_R); chk("to_next_addr", abus[2], 16'h0001);
      req[2] = 0;
      step(); co(2, "to_next_t2", O_ST_R);
      step(); co(2, "to_next_t3", O_ST_R);
      step(); co(2, "to_next_done", O_DONE);

      // back-to-back with req held: read 0x0010 then write 0x0020
      req[0] = 1; we[0] = 0; addr[0] = 16'h0010; ready[0] = 1;
      step(); co(0, "bb1_t1", O_T1_R); chk("bb1_addr", abus[0], 16'h0010);
      we[0] = 1; addr[0] = 16'h0020;
      step(); co(0, "bb1_t2", O_ST_R); chk("bb1_t2_addr", abus[0], 16'h0010);
      step(); co(0, "bb1_t3", O_ST_R);
      step(); co(0, "bb1_done", O_DONE); chk("bb1_done_addr", abus[0], 16'h0010);
      step(); co(0, "bb2_t1", O_T1_W); chk("bb2_addr", abus[0], 16'h0020);
      req[0] = 0;
      step(); co(0, "bb2_t2", O_ST_W);
      step(); co(0, "bb2_t3", O_ST_W);
      step(); co(0, "bb2_done", O_DONE);

      // reset during TW of a write
      req[0] = 1; we[0] = 1; addr[0] = 16'h7777; ready[0] = 0;
      step(); co(0, "rs_t1", O_T1_W);
      req[0] = 0;
      step(); co(0, "rs_t2", O_ST_W);
      step(); co(0, "rs_tw", O_ST_W);
      rst = 1'b1;
      step(); co(0, "rs_reset", O_IDLE); chk("rs_addr", abus[0], 16'h0000);
      step(); co(0, "rs_hold", O_IDLE);
      rst = 1'b0;
      step(); co(0, "rs_after", O_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Bus-cycle sequencer that sits directly upstream of the data bus in/out buffer.
- Accepts one read or write request at a time from the internal core and runs an external bus cycle: address phase, strobe phase, READY-extended wait states, then termination.
- Drives the buffer direction controls (Internal_RD_WR, RD_WR), the external strobes and the latched address.
- Returns completion or timeout to the core.

Parameters:
- ADDR_W, 16, width of address path.
- MIN_WAIT, 0, wait states always inserted before READY is sampled (0..15).
- TIMEOUT, 255, maximum number of READY-low cycles before the cycle aborts (1..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  core requests a bus cycle; sampled only in IDLE.
- we  in  1  request type: 0 read, 1 write; captured with req.
- addr  in  ADDR_W  request address; captured with req.
- READY  in  1  external ready; 1 ends wait states.
- busy  out  1  1 from the cycle after acceptance until done/timeout is pulsed.
- done  out  1  one-cycle pulse: cycle completed normally.
- timeout  out  1  one-cycle pulse: cycle aborted by wait-state limit.
- AddrBus  out  ADDR_W  registered external address.
- ALE  out  1  address latch enable, high in T1 only.
- RD_n  out  1  active-low external read strobe.
- WR_n  out  1  active-low external write strobe.
- Internal_RD_WR  out  1  buffer internal-side direction: 0 read (IRD), 1 write (IWR).
- RD_WR  out  1  buffer external-side direction: 0 read (RD), 1 write (WR).

Behaviour:
- Reset values, held while rst=1 at any point, including mid-cycle:
  - state IDLE; busy=0, done=0, timeout=0, ALE=0, RD_n=1, WR_n=1.
  - Internal_RD_WR=0, RD_WR=0, AddrBus=0, wait and timeout counters=0.
- States: IDLE, T1, T2, TW, T3.
- IDLE:
  - req=1 at edge: capture we into cyc_we and addr into AddrBus; go to T1.
  - req=0: stay in IDLE.
- T1:
  - ALE=1, busy=1, strobes inactive.
  - Internal_RD_WR=RD_WR=cyc_we.
  - Next state T2.
- T2:
  - ALE=0; RD_n=0 if read, WR_n=0 if write.
  - Load wait counter with MIN_WAIT.
  - If MIN_WAIT=0 and READY=1, go to T3; otherwise go to TW.
- TW:
  - Strobe held.
  - While wait counter is nonzero: decrement it and ignore READY.
  - Once it is zero: READY=1 goes to T3; READY=0 increments the timeout counter.
  - Timeout counter reaching TIMEOUT: release strobes, pulse timeout, go to IDLE.
  - The timeout counter clears on entry to T1.
- T3:
  - Strobe still asserted (data sampled by the buffer at the end of T3).
  - On exit: strobes deassert, done pulses for 1 cycle, go to IDLE.
  - busy drops in the same cycle done is high.
- Direction outputs:
  - Held at cyc_we from T1 through T3.
  - Return to 0 (read/idle default) in IDLE.
  - Never change while a strobe is asserted.
- Strobes:
  - RD_n and WR_n are never low simultaneously.
  - Both are 1 in IDLE and T1.
- Latency: the minimum cycle (MIN_WAIT=0, READY=1) is accept edge, then T1, T2, T3, with done in the IDLE cycle after T3: 4 clocks from req to done.
- Back-to-back: req held high while done is pulsing is accepted on that same edge (IDLE→T1 directly); no idle bubble is required beyond that cycle.
- req is ignored while busy. addr and we changes mid-cycle have no effect.
- Counter widths: wait counter 4 bits; timeout counter 8 bits, saturating, and it never wraps.
- done and timeout are mutually exclusive.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=0, T1=1, T2=2, TW=3, T3=4).
  - direction encodings DIR_RD=0, DIR_WR=1, used by both this block and the buffer.
- One natural sub-module, wait_state_ctr: loadable down-counter for MIN_WAIT plus saturating up-counter for TIMEOUT. It takes load, enable and READY, and outputs wait_zero and expired.

Test Plan:
- Read, MIN_WAIT=0, READY=1, addr=16'h1234, we=0:
  - ALE high 1 cycle with AddrBus=1234.
  - RD_n low exactly 2 cycles (T2, T3); WR_n stays 1.
  - Internal_RD_WR=RD_WR=0 throughout.
  - done 4 clocks after req.
- Write, addr=16'hABCD, we=1, READY low 3 cycles then high:
  - WR_n low for 2+3 cycles.
  - Both direction outputs 1 from T1 to T3.
  - done pulses once; busy drops with it.
- MIN_WAIT=2, READY tied 1: exactly 2 TW cycles inserted; strobe low 4 cycles.
- TIMEOUT=4, READY tied 0:
  - timeout pulses after 4 TW cycles; done never asserts.
  - Strobes released; state returns to IDLE and accepts the next req.
- req held high for two requests (read 0x0010, then write 0x0020):
  - Second T1 starts the cycle after the first done.
  - AddrBus updates to 0020 only at the second acceptance.
- rst=1 asserted during TW of a write:
  - Next edge gives WR_n=1, direction outputs 0, busy=0, no done or timeout pulse.
  - AddrBus=0.
